// File: rtl/strobe_sampler_pkg.sv
// Shared types and sizing helpers for the strobe sampler and its event ports.
package strobe_sampler_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Width of the strobe divider counter, never narrower than one bit.
    function automatic int unsigned div_cnt_w(input int unsigned div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/strobe_sampler_hit_slot.sv
// One-entry valid/ready holding register; a push into an occupied, non-draining
// slot is refused and flagged on drop for that cycle.
module hit_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         drop
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         pop;

    always_comb begin
        pop     = valid_q && ready;
        valid_d = valid_q;
        data_d  = data_q;
        drop    = 1'b0;
        if (push && (!valid_q || pop)) begin
            valid_d = 1'b1;
            data_d  = push_data;
        end else if (push) begin
            drop = 1'b1;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/strobe_sampler.sv
// Divide-by-DIV strobe sampling a free-running counter on the same clock;
// all-ones samples are reported as timestamped hits until MAX_CYC enabled cycles.
module strobe_sampler
    import strobe_sampler_pkg::*;
#(
    parameter int unsigned DIV     = 2,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned TS_W    = 8,
    parameter int unsigned MAX_CYC = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    output logic            strobe_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic            hit_valid,
    input  logic            hit_ready,
    output logic [TS_W-1:0] hit_data,
    output logic            overflow,
    output logic            done
);

    localparam int unsigned     DW       = div_cnt_w(DIV);
    localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);
    localparam logic [TS_W-1:0] CYC_LAST = TS_W'(MAX_CYC - 1);
    localparam logic [TS_W-1:0] CYC_MAX  = TS_W'(MAX_CYC);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TS_W-1:0]  cyc_q, cyc_d;
    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic             strobe_q, strobe_d;
    logic             done_q, done_d;
    logic             overflow_q, overflow_d;
    logic             active, sample, hit, drop;

    // IDLE behaves like RUN on an enabled edge, so the first enabled edge counts.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cyc_d      = cyc_q;
        div_cnt_d  = div_cnt_q;
        strobe_d   = 1'b0;
        done_d     = done_q;
        overflow_d = overflow_q | drop;
        active     = en && (state_q != DONE);
        sample     = active && (div_cnt_q == DIV_LAST);
        hit        = sample && (cnt_q == '1);
        if (active) begin
            cnt_d     = cnt_q + 1'b1;
            cyc_d     = (cyc_q == CYC_MAX) ? cyc_q : cyc_q + 1'b1;
            div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
            strobe_d  = sample;
            if (cyc_q == CYC_LAST) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cyc_q      <= '0;
            div_cnt_q  <= '0;
            strobe_q   <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cyc_q      <= cyc_d;
            div_cnt_q  <= div_cnt_d;
            strobe_q   <= strobe_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    hit_slot #(
        .W(TS_W)
    ) u_hit_slot (
        .clk      (clk),
        .reset    (reset),
        .push     (hit),
        .push_data(cyc_q),
        .ready    (hit_ready),
        .valid    (hit_valid),
        .data     (hit_data),
        .drop     (drop)
    );

    assign strobe_o = strobe_q;
    assign cnt_o    = cnt_q;
    assign overflow = overflow_q;
    assign done     = done_q;

endmodule
